axis_frame_loopback: RTL and testbench
======================================

// Module: axis_frame_loopback
// PURPOSE
//  Store-and-forward AXI-Stream frame loopback; replaces the direct RX->TX wire between the RMII MAC ports.
//  Buffers whole received frames, emits only complete good frames, honours TX tready backpressure,
//  drops bad, oversize or overflowing frames, and optionally transforms the payload. Counts rx/tx/drop.
// PARAMETERS
//  DATA_WIDTH  8      beat width in bits; MODE 2 XOR key and MODE 3 increment use this width
//  DEPTH       2048   buffer entries (beats); power of 2; AW = $clog2(DEPTH)
//  MAX_FRAME   1518   max beats per frame; a longer frame is dropped
//  XOR_KEY     8'hFF  DATA_WIDTH-bit key for MODE 2
//  CNT_WIDTH   16     width of the status counters
// PORTS
//  axis_aclk        in   1           single clock for both stream interfaces
//  axis_aresetn     in   1           asynchronous active-low reset
//  mode             in   2           0 pass, 1 drop all, 2 XOR payload with XOR_KEY, 3 add 1 to each beat
//  s_axis_tdata     in   DATA_WIDTH  RX beat from the MAC
//  s_axis_tvalid    in   1           RX beat valid
//  s_axis_tlast     in   1           last beat of the RX frame
//  s_axis_tuser     in   1           error flag; high on any beat marks the frame bad
//  s_axis_tready    out  1           0 in reset, 1 at all other times; overflow drops frames and never stalls RX
//  m_axis_tdata     out  DATA_WIDTH  TX beat to the MAC
//  m_axis_tvalid    out  1           TX beat valid
//  m_axis_tlast     out  1           last beat of the TX frame
//  m_axis_tready    in   1           TX accept
//  frames_rx        out  CNT_WIDTH   good frames committed
//  frames_tx        out  CNT_WIDTH   frames fully sent, counted on the tlast handshake
//  frames_dropped   out  CNT_WIDTH   frames discarded for any reason
// BEHAVIOUR
//  - Reset: all pointers, counters, m_axis_tvalid, m_axis_tdata, m_axis_tlast and s_axis_tready are 0.
//    Any partial frame is lost. FSM returns to IDLE.
//  - Storage: memory of {tlast, tdata}. Pointers wr_ptr (speculative), wr_commit and rd_ptr are AW+1 bits.
//    used = wr_ptr - rd_ptr, using rd_ptr at the start of the cycle. A same-cycle read does not free space.
//  - Write FSM. A beat is an input handshake (s_axis_tvalid && s_axis_tready).
//    IDLE: a beat latches mode for the whole frame, then is handled exactly as in WRITE.
//    WRITE: the beat is bad if tuser=1, latched mode=1, used==DEPTH, or it is beat MAX_FRAME+1.
//      Bad beat, tlast=0: wr_ptr <= wr_commit; go to DISCARD.
//      Bad beat, tlast=1: wr_ptr <= wr_commit; frames_dropped++; go to IDLE.
//      Good beat: write transformed data at wr_ptr; wr_ptr++.
//      Good beat with tlast=1 also sets wr_commit <= wr_ptr+1, does frames_rx++ and goes to IDLE.
//    DISCARD: swallow beats with no write. On tlast: frames_dropped++, go to IDLE.
//  - Transform at write time: mode 2 gives d^XOR_KEY; mode 3 gives d+1 mod 2^DATA_WIDTH.
//  - Read side: data is readable while rd_ptr != wr_commit, so partial frames are never exposed.
//    A registered output stage prefetches the next beat. m_axis_tvalid rises 2 cycles after the committing tlast beat.
//    While m_axis_tvalid && !m_axis_tready, tdata and tlast are held stable. Full throughput is 1 beat/clk with tready=1.
//    Once m_axis_tvalid is high it stays high until its handshake.
//  - Counters wrap modulo 2^CNT_WIDTH.
//  - Simultaneous commit and read is legal. Pointer wrap is handled by the modulo AW+1 arithmetic.
// TESTING
//  1. mode=0, 4-beat frame 01 02 03 04, tready=1 -> same 4 beats out, tlast on 04, valid 2 clk after the input tlast.
//     Afterwards frames_rx=1 and frames_tx=1.
//  2. mode=2, frame 00 0F F0 -> out FF F0 0F. mode=3, frame FF 10 -> out 00 11.
//  3. tuser=1 on beat 2 of 5, then a good 3-beat frame -> only the 3-beat frame is emitted.
//     frames_dropped=1; wr_ptr is restored so no stale beats appear.
//  4. DEPTH=16, tready=0, send 10-beat then 10-beat frames -> the 2nd is dropped.
//     Set tready=1 -> only the 1st frame is output and frames_dropped=1.
//  5. tready toggled 1/0 each clk over a 6-beat frame -> all 6 beats are in order and data is stable during stalls.
//  6. Assert axis_aresetn low mid-frame on both sides -> outputs and counters 0.
//     After release, a new 2-beat frame loops back correctly.

Source files
------------

// File: rtl/axis_frame_loopback.sv
// Store-and-forward AXI-Stream frame loopback: buffers whole frames, forwards only complete good ones,
// drops bad/oversize/overflowing frames and optionally transforms the payload at write time.
module axis_frame_loopback #(
  parameter int unsigned                  DATA_WIDTH = 8,
  parameter int unsigned                  DEPTH      = 2048,
  parameter int unsigned                  MAX_FRAME  = 1518,
  parameter logic [DATA_WIDTH-1:0]        XOR_KEY    = DATA_WIDTH'(8'hFF),
  parameter int unsigned                  CNT_WIDTH  = 16
) (
  input  logic                  axis_aclk,
  input  logic                  axis_aresetn,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [CNT_WIDTH-1:0]  frames_rx,
  output logic [CNT_WIDTH-1:0]  frames_tx,
  output logic [CNT_WIDTH-1:0]  frames_dropped
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(MAX_FRAME + 1);
  localparam logic [AW:0]   FullLevel = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] MaxCnt    = CW'(MAX_FRAME);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StWrite   = 2'd1;
  localparam logic [1:0] StDiscard = 2'd2;

  logic [DATA_WIDTH:0] mem [DEPTH];

  logic [1:0]            state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           wr_commit_q, wr_commit_d;
  logic [AW:0]           rd_ptr_q;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_valid_q, m_last_q;
  logic [CNT_WIDTH-1:0]  rx_cnt_q, tx_cnt_q, drop_cnt_q;

  logic                  beat, bad, we, rx_inc, drop_inc;
  logic [1:0]            eff_mode;
  logic [CW-1:0]         cur_cnt;
  logic [AW:0]           used;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rd_avail, rd_load;
  logic [DATA_WIDTH:0]   rd_word;

  assign beat     = s_axis_tvalid && ready_q;
  // Mode is sampled on the first beat of a frame and held for the rest of it.
  assign eff_mode = (state_q == StIdle) ? mode : mode_q;
  assign cur_cnt  = (state_q == StIdle) ? '0 : cnt_q;
  assign used     = wr_ptr_q - rd_ptr_q;
  assign bad      = s_axis_tuser || (eff_mode == 2'd1) || (used == FullLevel) ||
                    (cur_cnt == MaxCnt);

  always_comb begin
    unique case (eff_mode)
      2'd2:    wdata = s_axis_tdata ^ XOR_KEY;
      2'd3:    wdata = s_axis_tdata + 1'b1;
      default: wdata = s_axis_tdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    we          = 1'b0;
    rx_inc      = 1'b0;
    drop_inc    = 1'b0;
    if (beat) begin
      case (state_q)
        StIdle, StWrite: begin
          mode_d = eff_mode;
          if (bad) begin
            // Rewind to the last committed frame so no partial data is ever exposed.
            wr_ptr_d = wr_commit_q;
            cnt_d    = '0;
            if (s_axis_tlast) begin
              drop_inc = 1'b1;
              state_d  = StIdle;
            end else begin
              state_d  = StDiscard;
            end
          end else begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            cnt_d    = cur_cnt + 1'b1;
            state_d  = StWrite;
            if (s_axis_tlast) begin
              wr_commit_d = wr_ptr_q + 1'b1;
              rx_inc      = 1'b1;
              cnt_d       = '0;
              state_d     = StIdle;
            end
          end
        end
        StDiscard: begin
          if (s_axis_tlast) begin
            drop_inc = 1'b1;
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q     <= StIdle;
      mode_q      <= 2'd0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      ready_q     <= 1'b0;
      rx_cnt_q    <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      ready_q     <= 1'b1;
      if (rx_inc)   rx_cnt_q   <= rx_cnt_q + 1'b1;
      if (drop_inc) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (we) mem[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, wdata};
  end

  assign rd_avail = (rd_ptr_q != wr_commit_q);
  assign rd_load  = rd_avail && (!m_valid_q || m_axis_tready);
  assign rd_word  = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      rd_ptr_q  <= '0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
      tx_cnt_q  <= '0;
    end else begin
      if (m_valid_q && m_axis_tready && m_last_q) tx_cnt_q <= tx_cnt_q + 1'b1;
      if (rd_load) begin
        m_data_q  <= rd_word[DATA_WIDTH-1:0];
        m_last_q  <= rd_word[DATA_WIDTH];
        m_valid_q <= 1'b1;
        rd_ptr_q  <= rd_ptr_q + 1'b1;
      end else if (m_axis_tready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign s_axis_tready  = ready_q;
  assign m_axis_tdata   = m_data_q;
  assign m_axis_tvalid  = m_valid_q;
  assign m_axis_tlast   = m_last_q;
  assign frames_rx      = rx_cnt_q;
  assign frames_tx      = tx_cnt_q;
  assign frames_dropped = drop_cnt_q;

endmodule

// File: tb/tb_axis_frame_loopback.sv
// Scoreboard bench for axis_frame_loopback with a small buffer and short maximum frame.
module tb_axis_frame_loopback;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [1:0]  mode;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tlast, s_tuser, s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, m_tready;
  logic [15:0] frames_rx, frames_tx, frames_dropped;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [8:0]  exp_q[$];
  logic [7:0]  fr[$];
  int          exp_rx = 0, exp_tx = 0, exp_drop = 0;
  int          ready_ctl = 1;
  bit          stall_prev = 1'b0;
  logic [8:0]  prev_word;

  always #5 clk = ~clk;

  axis_frame_loopback #(
    .DATA_WIDTH (8),
    .DEPTH      (16),
    .MAX_FRAME  (12),
    .XOR_KEY    (8'hFF),
    .CNT_WIDTH  (16)
  ) dut (
    .axis_aclk      (clk),
    .axis_aresetn   (aresetn),
    .mode           (mode),
    .s_axis_tdata   (s_tdata),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tlast   (s_tlast),
    .s_axis_tuser   (s_tuser),
    .s_axis_tready  (s_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tlast   (m_tlast),
    .m_axis_tready  (m_tready),
    .frames_rx      (frames_rx),
    .frames_tx      (frames_tx),
    .frames_dropped (frames_dropped)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xf(input logic [1:0] m, input logic [7:0] d);
    case (m)
      2'd2:    return d ^ 8'hFF;
      2'd3:    return d + 8'd1;
      default: return d;
    endcase
  endfunction

  // Drives fr[] as one frame; beat index err_beat (0-based) carries tuser.
  task automatic send_frame(input logic [1:0] m, input int err_beat, input bit good);
    if (good) begin
      for (int i = 0; i < fr.size(); i++) exp_q.push_back({i == fr.size() - 1, xf(m, fr[i])});
      exp_rx++;
    end else begin
      exp_drop++;
    end
    for (int i = 0; i < fr.size(); i++) begin
      mode     = m;
      s_tdata  = fr[i];
      s_tvalid = 1'b1;
      s_tlast  = (i == fr.size() - 1);
      s_tuser  = (i == err_beat);
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic fill(input logic [7:0] base, input int n);
    fr.delete();
    for (int i = 0; i < n; i++) fr.push_back(base + 8'(i));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check({"drain_", tag}, exp_q.size(), 0);
    check({"idle_valid_", tag}, m_tvalid, 0);
    check({"rx_", tag}, frames_rx, exp_rx);
    check({"tx_", tag}, frames_tx, exp_tx);
    check({"drop_", tag}, frames_dropped, exp_drop);
  endtask

  // TX ready pattern: 0 low, 1 high, 2 toggle every clock.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_ctl)
        0:       m_tready = 1'b0;
        2:       m_tready = ~m_tready;
        default: m_tready = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!aresetn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", m_tvalid, 1);
        check("hold_word", {m_tlast, m_tdata}, prev_word);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", m_tvalid, 0);
        end else begin
          logic [8:0] w;
          w = exp_q.pop_front();
          check("beat", {m_tlast, m_tdata}, w);
          if (w[8]) exp_tx++;
        end
      end
      stall_prev = m_tvalid && !m_tready;
      prev_word  = {m_tlast, m_tdata};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn  = 1'b0;
    mode     = 2'd0;
    s_tdata  = 8'h00;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_frames_rx", frames_rx, 0);
    aresetn = 1'b1;
    @(posedge clk);
    #1;
    check("s_tready_up", s_tready, 1);

    // Pass-through and output latency
    fr = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(2'd0, -1, 1'b1);
    @(negedge clk);
    check("lat_cycle1", m_tvalid, 0);
    @(negedge clk);
    check("lat_cycle2", m_tvalid, 1);
    drain("pass");

    // Payload transforms
    fr = '{8'h00, 8'h0F, 8'hF0};
    send_frame(2'd2, -1, 1'b1);
    fr = '{8'hFF, 8'h10};
    send_frame(2'd3, -1, 1'b1);
    drain("xform");

    // Errored frame followed by a good one
    fill(8'h50, 5);
    send_frame(2'd0, 1, 1'b0);
    fill(8'hA0, 3);
    send_frame(2'd0, -1, 1'b1);
    drain("tuser");

    // Drop-all mode
    fill(8'h30, 3);
    send_frame(2'd1, -1, 1'b0);
    drain("mode1");

    // Frame length boundary: MAX_FRAME passes, MAX_FRAME+1 is dropped
    fill(8'h60, 13);
    send_frame(2'd0, -1, 1'b0);
    fill(8'h70, 12);
    send_frame(2'd0, -1, 1'b1);
    drain("maxlen");

    // Overflow under backpressure
    ready_ctl = 0;
    repeat (2) @(posedge clk);
    #1;
    fill(8'h80, 10);
    send_frame(2'd0, -1, 1'b1);
    fill(8'h90, 10);
    send_frame(2'd0, -1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("ovf_drop", frames_dropped, exp_drop);
    check("ovf_tx_stalled", frames_tx, 0 + exp_tx);
    ready_ctl = 1;
    drain("overflow");

    // Toggling backpressure
    ready_ctl = 2;
    fill(8'hC0, 6);
    send_frame(2'd0, -1, 1'b1);
    drain("toggle");
    ready_ctl = 1;

    // Reset with a stored frame and a partial incoming frame
    ready_ctl = 0;
    repeat (2) @(posedge clk);
    #1;
    fill(8'hD0, 10);
    send_frame(2'd0, -1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      s_tdata  = 8'hE0 + 8'(i);
      s_tvalid = 1'b1;
      @(posedge clk);
      #1;
    end
    aresetn = 1'b0;
    #1;
    check("mid_rst_valid", m_tvalid, 0);
    check("mid_rst_tdata", m_tdata, 0);
    check("mid_rst_rx", frames_rx, 0);
    check("mid_rst_tx", frames_tx, 0);
    check("mid_rst_drop", frames_dropped, 0);
    check("mid_rst_tready", s_tready, 0);
    s_tvalid = 1'b0;
    exp_q.delete();
    exp_rx   = 0;
    exp_tx   = 0;
    exp_drop = 0;
    ready_ctl = 1;
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    fr = '{8'h5A, 8'hA5};
    send_frame(2'd0, -1, 1'b1);
    drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
